// File: rtl/mem_lsu_rmw.sv
// Load/store unit for a word-addressed single-port data memory: byte/half/word
// accesses, read-modify-write for sub-word stores. Option macro: LSU_MISALIGN_ERR_EN.
`timescale 1ns/1ps

module mem_lsu_rmw #(
    parameter int WORD_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 we_q;
    logic                 uns_q;
    logic [1:0]           size_q;
    logic [WORD_AW+1:0]   addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rd_q;
    logic [31:0]          rdata_q;

    logic                 accept;
    logic                 flag_err;
    logic                 sub_word_in;
    logic [3:0]           lane_en;
    logic [31:0]          wdata_rep;
    logic [31:0]          merged;
    logic [7:0]           rd_lane [4];
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [31:0]          load_ext;

    // Address bits above the memory depth are deliberately dropped (wrap).
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^addr[31:WORD_AW+2];

    assign accept      = (state_q == IDLE) && req;
    assign sub_word_in = (size == SZ_BYTE) || (size == SZ_HALF);

`ifdef LSU_MISALIGN_ERR_EN
    logic err_q;

    assign flag_err = (size == 2'b11)
                   || ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign err      = (state_q == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= flag_err;
        end
    end
`else
    assign flag_err = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (flag_err) begin
                        state_d = DONE;
                    end else if (we && !sub_word_in) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = we_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= we;
                uns_q   <= uns;
                size_q  <= size;
                addr_q  <= addr[WORD_AW+1:0];
                wdata_q <= wdata;
            end
            if (state_q == READ) begin
                rd_q <= mem_rdata;
                if (!we_q) begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

    // Lane enables; misaligned halves/words and size 11 fall through to aligned forms.
    always_comb begin
        lane_en   = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                lane_en   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8] : rd_q[8*gi +: 8];
            assign rd_lane[gi]       = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign load_byte = rd_lane[addr_q[1:0]];
    assign load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h000000, load_byte}
                                      : {{24{load_byte[7]}}, load_byte};
            SZ_HALF: load_ext = uns_q ? {16'h0000, load_half}
                                      : {{16{load_half[15]}}, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Write port is driven purely from registered state, so it is stable through WRITE.
    assign mem_wen   = (state_q == WRITE);
    assign mem_addr  = {{(32-WORD_AW){1'b0}}, addr_q[WORD_AW+1:2]};
    assign mem_wdata = merged;

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// Self-checking bench for mem_lsu_rmw: directed plan items, back-to-back,
// mid-operation reset and random accesses against a byte-array reference model.
`timescale 1ns/1ps

module tb_mem_lsu_rmw;

`ifdef LSU_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_lsu_rmw #(.WORD_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory block seen by the unit, plus a preload port used during reset.
    logic [31:0] memw [32];
    logic        tb_load = 1'b0;
    logic [4:0]  tb_idx  = 5'd0;
    logic [31:0] tb_val  = 32'd0;
    int          wen_cnt = 0;

    assign mem_rdata = memw[mem_addr[4:0]];

    always @(posedge clk) begin
        if (tb_load) begin
            memw[tb_idx] <= tb_val;
        end else if (mem_wen) begin
            memw[mem_addr[4:0]] <= mem_wdata;
        end
        if (mem_wen) wen_cnt <= wen_cnt + 1;
    end

    // Reference model: plain byte-addressed memory, 128 bytes.
    logic [7:0]  ref_mem [128];
    logic [31:0] last_rd = 32'd0;
    logic [31:0] got_rd  = 32'd0;
    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        return ERR_EN && ((sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int b;
        b = int'(a[6:0]);
        if (sz == 2'd0) begin
            ref_mem[b] = d[7:0];
        end else if (sz == 2'd1) begin
            b = b - (b % 2);
            ref_mem[b]   = d[7:0];
            ref_mem[b+1] = d[15:8];
        end else begin
            b = b - (b % 4);
            for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        int b;
        logic [15:0] h;
        b = int'(a[6:0]);
        if (sz == 2'd0) begin
            return u ? {24'd0, ref_mem[b]} : {{24{ref_mem[b][7]}}, ref_mem[b]};
        end else if (sz == 2'd1) begin
            b = b - (b % 2);
            h = {ref_mem[b+1], ref_mem[b]};
            return u ? {16'd0, h} : {{16{h[15]}}, h};
        end
        return ref_word(b / 4);
    endfunction

    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        int lat, wen0, exp_lat, exp_wen, widx;
        bit mis;
        logic [31:0] wa, wd, got_e;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        mis     = is_mis(sz, a);
        exp_lat = mis ? 1 : ((w && sz < 2'd2) ? 3 : 2);
        exp_wen = (mis || !w) ? 0 : 1;
        widx    = int'(a[6:2]);
        if (!mis && w)  ref_store(a, sz, d);
        if (!mis && !w) last_rd = ref_load(a, sz, u);
        wen0 = wen_cnt; wa = '0; wd = '0; lat = 0; got_e = '0;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_wen) begin
                wa = mem_addr;
                wd = mem_wdata;
            end
            if (done) begin
                lat = c; got_e = {31'd0, err}; got_rd = rdata;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", got_e, {31'd0, mis});
        chk("rdata", got_rd, last_rd);
        chk("wen_cycles", 32'(wen_cnt - wen0), 32'(exp_wen));
        chk("mem_word", memw[widx], ref_word(widx));
        if (exp_wen == 1) begin
            chk("mem_addr", wa, 32'(widx));
            chk("mem_wdata", wd, ref_word(widx));
        end
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
                 w, sz, u, a, d, lat, got_e[0], got_rd);
    endtask

    // Back-to-back request table.
    logic        bb_we   [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  bb_sz   [3] = '{2'd2, 2'd2, 2'd0};
    logic [31:0] bb_addr [3] = '{32'h20, 32'h20, 32'h21};
    logic [31:0] bb_data [3];
    logic [31:0] bb_exp  [3];

    task automatic drive_bb(input int i);
        we = bb_we[i]; size = bb_sz[i]; uns = 1'b0; addr = bb_addr[i]; wdata = bb_data[i];
    endtask

    initial begin
        int idx, nacc, ndone, extra, wen0;
        logic rdy;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;

        tb_load = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tb_idx = 5'(i);
            tb_val = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = tb_val[8*k +: 8];
            @(posedge clk);
            #1;
        end
        tb_load = 1'b0;

        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        access(1'b1, 2'd2, 1'b0, 32'h0000000C, 32'hDEADBEEF);
        chk("tp_word3_store", memw[3], 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 32'h0000000C, 32'h0);
        chk("tp_word_load", got_rd, 32'hDEADBEEF);
        access(1'b1, 2'd0, 1'b0, 32'h0000000E, 32'h000000AA);
        chk("tp_byte_store", memw[3], 32'hDEAABEEF);
        access(1'b0, 2'd0, 1'b0, 32'h0000000E, 32'h0);
        chk("tp_byte_load_s", got_rd, 32'hFFFFFFAA);
        access(1'b0, 2'd0, 1'b1, 32'h0000000E, 32'h0);
        chk("tp_byte_load_u", got_rd, 32'h000000AA);
        access(1'b0, 2'd1, 1'b0, 32'h0000000C, 32'h0);
        chk("tp_half_load_s", got_rd, 32'hFFFFBEEF);
        access(1'b1, 2'd1, 1'b0, 32'h0000000D, 32'h00001234);
        chk("tp_half_mis", memw[3], ERR_EN ? 32'hDEAABEEF : 32'hDEAA1234);
        access(1'b1, 2'd0, 1'b0, 32'hFFFFFF83, 32'h0000005A);

        // Back-to-back with req held high across three requests.
        bb_data[0] = $urandom; bb_data[1] = '0; bb_data[2] = '0;
        ref_store(bb_addr[0], 2'd2, bb_data[0]);
        bb_exp[0] = last_rd;
        last_rd   = ref_load(bb_addr[1], 2'd2, 1'b0);
        bb_exp[1] = last_rd;
        last_rd   = ref_load(bb_addr[2], 2'd0, 1'b0);
        bb_exp[2] = last_rd;
        @(negedge clk);
        idx = 0; nacc = 0; ndone = 0; wen0 = wen_cnt;
        req = 1'b1;
        drive_bb(0);
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            rdy = ready;
            if (done) begin
                chk("b2b_rdata", rdata, bb_exp[ndone]);
                ndone++;
            end
            @(posedge clk);
            #1;
            if (rdy && req) begin
                nacc++; idx++;
                if (idx < 3) drive_bb(idx);
                else req = 1'b0;
            end
            @(negedge clk);
        end
        req = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        chk("b2b_accepted", 32'(nacc), 32'd3);
        chk("b2b_done", 32'(ndone), 32'd3);
        chk("b2b_extra_done", 32'(extra), 32'd0);
        chk("b2b_wen", 32'(wen_cnt - wen0), 32'd1);
        chk("b2b_mem", memw[8], ref_word(8));
        $display("txn b2b accepted=%0d done=%0d", nacc, ndone);

        // Reset while a byte store sits in READ: nothing may be written.
        @(negedge clk);
        for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h46; wdata = 32'h55;
        wen0 = wen_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", {31'd0, ready}, 32'd1);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_wen", {31'd0, mem_wen}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_write", 32'(wen_cnt - wen0), 32'd0);
        chk("rstmid_mem", memw[17], ref_word(17));
        $display("txn reset during READ addr=%h", 32'h46);

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mem_lsu_rmw.md
Name: mem_lsu_rmw

Overview:
- Initiator-side load/store unit that drives the word-addressed, single-port data memory (wen/addr/wdata write port, asynchronous rdata read port).
- Accepts byte-addressed byte/halfword/word loads and stores from the core over a req/ready handshake.
- Word stores are written directly. Sub-word stores use read-modify-write. Loads are extracted and extended from the word read.
- Sits between the core datapath and the memory block.

Parameters:
- WORD_AW, 5, word-index width; memory depth = 2**WORD_AW words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; accepted only when ready=1
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- uns  in  1  load zero-extend (1) / sign-extend (0)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- ready  out  1  unit idle, can accept req
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  load result, valid while done=1, held until next load completes
- err  out  1  one-cycle misalign/reserved pulse (feature only, else tied 0)
- mem_wen  out  1  memory write enable
- mem_addr  out  32  word index = {zeros, addr_q[WORD_AW+1:2]}
- mem_wdata  out  32  merged write word
- mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Handshake: req sampled only when state=IDLE. On acceptance, latch we/size/uns/addr/wdata into *_q. req is ignored while busy, so no queuing.
- mem_addr and mem_wdata come only from registers. mem_wen is decoded from the state register and is high only in WRITE.
- Address and data are stable for the whole cycle in which mem_wen=1.
- States:
  - IDLE: ready=1. On accepted req:
    - word store goes to WRITE.
    - byte/half store goes to READ.
    - load goes to READ.
  - READ: capture mem_rdata into rd_q.
    - If a load, go to DONE.
    - If a store, go to WRITE.
  - WRITE: mem_wen=1, one cycle only.
    - mem_wdata for a word store = wdata_q.
    - mem_wdata for a sub-word store = rd_q with the target lanes replaced. Go to DONE.
  - DONE: done=1, rdata updated for loads, go to IDLE.
- Latency from acceptance edge to done:
  - word store: 2 cycles
  - load: 2 cycles
  - byte/half store: 3 cycles
  - Next req is accepted in the cycle after done.
- Lanes are little-endian. Byte k = bits 8k+7:8k, with k = addr_q[1:0].
- Halfword lane = addr_q[1] (bits 15:0 or 31:16).
- Load extension: byte and half are sign- or zero-extended per uns_q. A word load is passed through.
- Without the optional feature, misaligned addresses are force-aligned:
  - halfword ignores addr[0]
  - word ignores addr[1:0]
  - size 11 is treated as word
- Address bits above WORD_AW+1 are ignored, so addresses wrap modulo memory size.
- Reset mid-operation: at the next edge the unit returns to IDLE with mem_wen=0. A partially completed RMW writes nothing. rdata is cleared.

Optional Feature:
- Macro: LSU_MISALIGN_ERR_EN.
- Defined:
  - Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) and size=11 are flagged.
  - A flagged access goes IDLE->DONE with no memory read or write.
  - err=1 and done=1 in the same cycle. rdata is unchanged.
- Undefined: force-align behaviour as above, and err is tied 0.

Test Plan:
- Word store addr=0x0000000C, wdata=0xDEADBEEF -> mem_wen high exactly 1 cycle, mem_addr=3, mem_wdata=0xDEADBEEF, done 2 cycles after acceptance. Following word load of 0x0C returns 0xDEADBEEF.
- With word 3 = 0xDEADBEEF, byte store addr=0x0E wdata=0x000000AA -> READ then WRITE, mem_wdata=0xDEAABEEF, done 3 cycles after acceptance.
- With word 3 = 0xDEAABEEF:
  - byte load addr=0x0E, uns=0 -> rdata=0xFFFFFFAA
  - uns=1 -> 0x000000AA
  - half load addr=0x0C, uns=0 -> 0xFFFFBEEF
- Back-to-back: req held high for 3 requests -> each accepted only when ready=1. No request is lost or duplicated, and done pulses in order.
- Assert rst during the READ state of a byte store -> next cycle state=IDLE, ready=1, mem_wen never asserted, and the memory word is unchanged.
- Half store addr=0x0D:
  - with LSU_MISALIGN_ERR_EN -> err=1 and done=1 one cycle after acceptance, no mem_wen.
  - without it -> written to bits 15:0 of word 3.
